// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared op and FSM encodings for the multiply/divide unit and ALU decoder.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] c_OP_MULTU = 2'b00;
    localparam logic [1:0] c_OP_MULT  = 2'b01;
    localparam logic [1:0] c_OP_DIVU  = 2'b10;
    localparam logic [1:0] c_OP_DIV   = 2'b11;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PREP = 3'd1;
    localparam logic [2:0] c_ST_ITER = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == c_OP_DIVU) || (op == c_OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == c_OP_MULT) || (op == c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Revision : 1.0
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_add_sum;
    logic [WIDTH:0]   w_trial;

    assign w_hi = i_acc[2*WIDTH-1:WIDTH];
    assign w_lo = i_acc[WIDTH-1:0];

    // Multiply: acc = {partial, multiplier}; add when the multiplier LSB is set, then shift right.
    assign w_add_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});

    // Divide: acc = {remainder, dividend/quotient}; the remainder stays below the divisor,
    // so the top bit of the trial difference is a clean borrow flag.
    assign w_trial = {w_hi, w_lo[WIDTH-1]} - {1'b0, i_operand};

    always_comb begin
        o_acc = '0;
        if (!i_div) begin
            o_acc = {w_add_sum, w_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            o_acc = {w_trial[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_hi[WIDTH-2:0], w_lo[WIDTH-1], w_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative signed/unsigned multiply and divide, WIDTH+3 cycles per result.
// Revision : 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_by_zero_o
);

    localparam int               c_SW   = $clog2(WIDTH);
    localparam logic [c_SW-1:0]  c_LAST = c_SW'(WIDTH - 1);

    logic [2:0]           r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_operand;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic [c_SW-1:0]      r_step;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dbz;

    logic                 w_div;
    logic                 w_signed;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]     w_acc_hi;
    logic [WIDTH-1:0]     w_acc_lo;
    logic [2*WIDTH-1:0]   w_fix_prod;
    logic [2*WIDTH-1:0]   w_fix_div;
    logic [2*WIDTH-1:0]   w_fix;

    assign w_div      = op_is_div(r_op);
    assign w_signed   = op_is_signed(r_op);
    assign w_div_zero = w_div && (r_b == '0);
    assign w_abs_a    = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b    = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    assign w_acc_hi   = r_acc[2*WIDTH-1:WIDTH];
    assign w_acc_lo   = r_acc[WIDTH-1:0];
    assign w_fix_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_fix_div  = {(r_neg_hi ? -w_acc_hi : w_acc_hi), (r_neg_lo ? -w_acc_lo : w_acc_lo)};
    assign w_fix      = w_div ? w_fix_div : w_fix_prod;

    muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_div     (w_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_ST_IDLE;
            r_op      <= c_OP_MULTU;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_step    <= '0;
            r_result  <= '0;
            r_dbz     <= 1'b0;
        end else begin
            r_dbz <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i && !annul_i) begin
                        r_op    <= op_i;
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_state <= c_ST_PREP;
                    end
                end
                c_ST_PREP: begin
                    if (annul_i) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_div_zero) begin
                        r_result <= {r_a, {WIDTH{1'b1}}};
                        r_dbz    <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else begin
                        // Multiplier sits in the low half for mul; dividend for div.
                        r_acc     <= {{WIDTH{1'b0}}, (w_div ? w_abs_a : w_abs_b)};
                        r_operand <= w_div ? w_abs_b : w_abs_a;
                        r_neg_lo  <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_hi  <= w_signed && r_a[WIDTH-1];
                        r_step    <= '0;
                        r_state   <= c_ST_ITER;
                    end
                end
                c_ST_ITER: begin
                    if (annul_i) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc  <= w_step_acc;
                        r_step <= r_step + 1'b1;
                        if (r_step == c_LAST) begin
                            r_state <= c_ST_FIX;
                        end
                    end
                end
                c_ST_FIX: begin
                    if (annul_i) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_result <= w_fix;
                        r_state  <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = (r_state != c_ST_IDLE);
    assign ready_o       = (r_state == c_ST_DONE);
    assign result_o      = r_result;
    assign div_by_zero_o = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed vector table plus abort/reset/hold sequences for muldiv_unit.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic           clk;
    logic           resetn;
    logic           start_i;
    logic           annul_i;
    logic [1:0]     op_i;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           busy_o;
    logic           ready_o;
    logic [2*W-1:0] result_o;
    logic           div_by_zero_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_res;
        logic           exp_dbz;
        int             exp_lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start_i       (start_i),
        .annul_i       (annul_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .busy_o        (busy_o),
        .ready_o       (ready_o),
        .result_o      (result_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request; start stays high throughout when hold is set (caller drops it).
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, output logic [2*W-1:0] res, output logic dbz,
                          output int lat, output int busy_cnt, output int stray_dbz);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        lat = 0; busy_cnt = 0; stray_dbz = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!hold) start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (div_by_zero_o && !ready_o) stray_dbz++;
        end while (!ready_o && lat < 200);
        res = result_o;
        dbz = div_by_zero_o;
    endtask

    task automatic watch(input int n, output int ready_cnt, output int busy_cnt);
        ready_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ready_o) ready_cnt++;
            if (busy_o) busy_cnt++;
        end
    endtask

    initial begin
        logic [2*W-1:0] res;
        logic [2*W-1:0] prev;
        logic           dbz;
        int             lat, bc, sd, rc;

        vecs[0]  = '{c_OP_DIVU,  32'd100,      32'd7,        {32'd2, 32'd14},              1'b0, 35};
        vecs[1]  = '{c_OP_DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 35};
        vecs[2]  = '{c_OP_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000},        1'b0, 35};
        vecs[3]  = '{c_OP_MULT,  32'hFFFFFFFF, 32'd2,        64'hFFFFFFFF_FFFFFFFE,        1'b0, 35};
        vecs[4]  = '{c_OP_MULTU, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE,        1'b0, 35};
        vecs[5]  = '{c_OP_DIVU,  32'd5,        32'd0,        {32'd5, 32'hFFFFFFFF},        1'b1, 2};
        vecs[6]  = '{c_OP_DIV,   32'hFFFFFFEC, 32'd0,        {32'hFFFFFFEC, 32'hFFFFFFFF}, 1'b1, 2};
        vecs[7]  = '{c_OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 64'h00000000_0000000F,        1'b0, 35};
        vecs[8]  = '{c_OP_DIV,   32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},        1'b0, 35};
        vecs[9]  = '{c_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001,        1'b0, 35};
        vecs[10] = '{c_OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},        1'b0, 35};
        vecs[11] = '{c_OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000,        1'b0, 35};
        vecs[12] = '{c_OP_MULT,  32'd7,        32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6,        1'b0, 35};
        vecs[13] = '{c_OP_DIVU,  32'hFFFFFFFF, 32'd16,       {32'hF, 32'h0FFFFFFF},        1'b0, 35};

        resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        check("reset_busy",   64'(busy_o),        64'd0);
        check("reset_ready",  64'(ready_o),       64'd0);
        check("reset_result", result_o,           64'd0);
        check("reset_dbz",    64'(div_by_zero_o), 64'd0);

        // start and annul together in IDLE: nothing starts
        start_i = 1'b1; annul_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_wins_busy", 64'(busy_o), 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, dbz, lat, bc, sd);
            check($sformatf("v%0d_result", i),  res,                 vecs[i].exp_res);
            check($sformatf("v%0d_dbz", i),     64'(dbz),            64'(vecs[i].exp_dbz));
            check($sformatf("v%0d_latency", i), 64'(lat),            64'(vecs[i].exp_lat));
            check($sformatf("v%0d_busy", i),    64'(bc),             64'(vecs[i].exp_lat));
            check($sformatf("v%0d_stray_dbz", i), 64'(sd),           64'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_busy_after", i), 64'(busy_o),      64'd0);
        end

        // abort 10 cycles into ITER
        prev = result_o;
        start_i = 1'b1; op_i = c_OP_DIVU; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul_busy",   64'(busy_o),  64'd0);
        check("annul_ready",  64'(ready_o), 64'd0);
        check("annul_result", result_o,     prev);
        watch(40, rc, bc);
        check("annul_no_ready", 64'(rc), 64'd0);
        run_op(c_OP_DIVU, 32'd9, 32'd3, 1'b0, res, dbz, lat, bc, sd);
        check("after_annul_result",  res,      {32'd0, 32'd3});
        check("after_annul_latency", 64'(lat), 64'd35);
        @(posedge clk); #1;

        // start held high through DONE: one pulse only
        run_op(c_OP_DIVU, 32'd100, 32'd7, 1'b1, res, dbz, lat, bc, sd);
        check("hold_result",  res,      {32'd2, 32'd14});
        check("hold_latency", 64'(lat), 64'd35);
        @(posedge clk); #1;
        start_i = 1'b0;
        watch(40, rc, bc);
        check("hold_no_second_ready", 64'(rc), 64'd0);
        check("hold_no_second_busy",  64'(bc), 64'd0);

        // annul during DONE still shows the pulse
        run_op(c_OP_MULTU, 32'd3, 32'd4, 1'b0, res, dbz, lat, bc, sd);
        annul_i = 1'b1;
        #1;
        check("done_annul_ready",  64'(ready_o), 64'd1);
        check("done_annul_result", result_o,     64'd12);
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("done_annul_busy_after", 64'(busy_o), 64'd0);

        // asynchronous reset mid-ITER
        start_i = 1'b1; op_i = c_OP_DIV; a_i = 32'hFFFFFF00; b_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        check("pre_reset_busy", 64'(busy_o), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("rst_busy",   64'(busy_o),        64'd0);
        check("rst_ready",  64'(ready_o),       64'd0);
        check("rst_result", result_o,           64'd0);
        check("rst_dbz",    64'(div_by_zero_o), 64'd0);
        @(negedge clk) resetn = 1'b1;
        watch(40, rc, bc);
        check("rst_no_ready", 64'(rc), 64'd0);
        check("rst_no_busy",  64'(bc), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
